// File: rtl/bus_master_fabric.sv
// Single-master register-bus front end: accepts one command, decodes the upper address
// bits to a slave port, waits for that slave's ready or a timeout, and returns a response.
module bus_master_fabric #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [N_SLAVES-1:0]          s_sel,
  output logic                         s_valid,
  output logic                         s_write,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [N_SLAVES-1:0]          s_ready,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata
);

  localparam int unsigned SEL_W = $clog2(N_SLAVES);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [SEL_W-1:0]    idx_q;
  logic                err_q;
  logic [TMR_W-1:0]    tmr_q;
  logic                accept;
  logic                hit;
  logic                expire;
  logic [DATA_W-1:0]   sel_rdata;

  // cmd_ready is gated by reset so nothing is advertised while reset is held
  assign cmd_ready = reset & (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign hit       = (state == REQ) & s_ready[idx_q];
  assign expire    = (state == REQ) & ~hit & (tmr_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (idx_q == SEL_W'(i)) sel_rdata = s_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = REQ;
      REQ:     if (hit || expire) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
    end else if (accept) begin
      wr_q    <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      idx_q   <= cmd_addr[ADDR_W-1 -: SEL_W];
      tmr_q   <= '0;
    end else if (state == REQ) begin
      // a ready arriving on the last allowed cycle still wins over the timeout
      if (hit) begin
        rdata_q <= wr_q ? '0 : sel_rdata;
        err_q   <= 1'b0;
      end else if (expire) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else begin
        tmr_q   <= tmr_q + 1'b1;
      end
    end
  end

  assign s_valid   = (state == REQ);
  assign s_sel     = s_valid ? (N_SLAVES'(1) << idx_q) : '0;
  assign s_write   = wr_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_bus_master_fabric.sv
// Randomized bench for bus_master_fabric: a transaction timeline model predicts every
// output cycle by cycle; a few literal checks pin the directed scenarios.
module tb_bus_master_fabric;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic            rsp_valid, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [NS-1:0]   s_sel;
  logic            s_valid, s_write;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [NS-1:0]   s_ready;
  logic [NS*DW-1:0] s_rdata;

  bus_master_fabric #(.ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .s_sel(s_sel), .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One planned transaction: cycle windows in which REQ and the response occur.
  typedef struct {
    int          req_first;
    int          req_last;
    int          rsp;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    logic [3:0]  sel;
  } plan_t;

  plan_t       q[$];
  int          free_cyc = 0;
  bit          in_reset = 1'b1;
  logic [31:0] hold_rdata = '0;
  int          total = 0;
  int          bad = 0;
  int          sv_cnt = 0;
  logic [3:0]  last_sel = '0;
  logic        last_write = 1'b0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (s_valid === 1'b1) begin
      sv_cnt++;
      last_sel   = s_sel;
      last_write = s_write;
      last_wdata = s_wdata;
    end
  end

  // Cycle-by-cycle comparison against the transaction timeline.
  always @(negedge clk) begin
    plan_t       p;
    bit          e_cready, e_sv, e_rv, e_rerr, in_req, at_rsp;
    logic [3:0]  e_sel;
    logic [31:0] e_rd;
    if (in_reset) begin
      hold_rdata = '0;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_s_valid",   64'(s_valid),   64'd0);
      chk("rst_s_sel",     64'(s_sel),     64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err",   64'(rsp_err),   64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_s_addr",    64'(s_addr),    64'd0);
      chk("rst_s_wdata",   64'(s_wdata),   64'd0);
    end else begin
      while (q.size() > 0 && q[0].rsp < cyc) void'(q.pop_front());
      e_cready = 1'b1; e_sv = 1'b0; e_sel = '0; e_rv = 1'b0; e_rerr = 1'b0;
      e_rd = hold_rdata; in_req = 1'b0; at_rsp = 1'b0;
      if (q.size() > 0) begin
        p = q[0];
        if (cyc >= p.req_first && cyc <= p.req_last) begin
          in_req = 1'b1; e_cready = 1'b0; e_sv = 1'b1; e_sel = p.sel;
        end else if (cyc == p.rsp) begin
          at_rsp = 1'b1; e_cready = 1'b0; e_rv = 1'b1; e_rerr = p.err; e_rd = p.rdata;
        end
      end
      chk("cmd_ready", 64'(cmd_ready), 64'(e_cready));
      chk("s_valid",   64'(s_valid),   64'(e_sv));
      chk("s_sel",     64'(s_sel),     64'(e_sel));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_err",   64'(rsp_err),   64'(e_rerr));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
      if (in_req) begin
        chk("s_write", 64'(s_write), 64'(p.wr));
        chk("s_addr",  64'(s_addr),  64'(p.addr));
        chk("s_wdata", 64'(s_wdata), 64'(p.wdata));
      end
      if (at_rsp) hold_rdata = p.rdata;
    end
  end

  function automatic logic [3:0] nz(input int mode, input logic [3:0] oh);
    case (mode)
      1:       return 4'($urandom) & ~oh;
      2:       return ~oh;
      default: return 4'b0000;
    endcase
  endfunction

  // Issues one command at the current cycle (called #1 after a rising edge) and plays
  // the selected slave: ready in REQ cycle d (0-based), never if d >= TO.
  task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        input int d, input bit keep, input int noise, input int abort_j,
                        input bit use_rd, input logic [31:0] rd);
    plan_t        p;
    int           a, k, idx;
    logic [3:0]   oh;
    logic [127:0] rdv;
    idx = int'(addr[7:6]);
    oh  = 4'b0001 << idx;
    for (int i = 0; i < NS; i++) rdv[i*DW +: DW] = $urandom;
    if (use_rd) rdv[idx*DW +: DW] = rd;
    s_rdata = rdv;
    a = (cyc > free_cyc) ? cyc : free_cyc;
    k = (d < TO) ? d + 1 : TO;
    p.req_first = a + 1;
    p.req_last  = a + k;
    p.rsp       = a + k + 1;
    p.wr        = wr;
    p.addr      = addr;
    p.wdata     = wd;
    p.err       = (d >= TO);
    p.rdata     = (p.err || wr) ? 32'd0 : rdv[idx*DW +: DW];
    p.sel       = oh;
    q.push_back(p);
    free_cyc  = a + k + 2;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    s_ready   = nz(noise, oh);
    while (cyc < a) begin
      @(posedge clk); #1;
      s_ready = nz(noise, oh);
    end
    for (int t = a + 1; t <= a + k + 1; t++) begin
      @(posedge clk); #1;
      if (!keep) cmd_valid = 1'b0;
      if (abort_j >= 0 && t == a + 1 + abort_j) begin
        reset     = 1'b0;
        in_reset  = 1'b1;
        q.delete();
        cmd_valid = 1'b0;
        s_ready   = '0;
        return;
      end
      s_ready = nz(noise, oh) | (((t - (a + 1)) == d && d < TO) ? oh : 4'b0000);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    int  base;
    bit  keep, keep_prev;
    int  d, g;
    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    s_ready = '0; s_rdata = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; in_reset = 1'b0; free_cyc = cyc;
    @(negedge clk);
    chk("lit_ready_after_rst", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // write 0x04 to slave 0, ready one cycle after REQ begins
    base = sv_cnt;
    do_txn(1'b1, 8'h04, 32'hDEADBEEF, 1, 1'b0, 0, -1, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("lit_wr_err",       64'(rsp_err),   64'd0);
    chk("lit_wr_rdata",     64'(rsp_rdata), 64'd0);
    chk("lit_wr_sel",       64'(last_sel),  64'b0001);
    chk("lit_wr_write",     64'(last_write), 64'd1);
    chk("lit_wr_wdata",     64'(last_wdata), 64'hDEADBEEF);
    chk("lit_wr_req_cycles", 64'(sv_cnt - base), 64'd2);
    @(posedge clk); #1;

    // read 0x04 at minimum latency
    base = sv_cnt;
    do_txn(1'b0, 8'h04, 32'd0, 0, 1'b0, 0, -1, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    chk("lit_rd_rdata",      64'(rsp_rdata), 64'hDEADBEEF);
    chk("lit_rd_err",        64'(rsp_err),   64'd0);
    chk("lit_rd_req_cycles", 64'(sv_cnt - base), 64'd1);
    @(posedge clk); #1;

    // read 0xC0 with only other slaves ready -> timeout
    base = sv_cnt;
    do_txn(1'b0, 8'hC0, 32'd0, TO + 2, 1'b0, 2, -1, 1'b0, 32'd0);
    @(negedge clk);
    chk("lit_to_err",        64'(rsp_err),   64'd1);
    chk("lit_to_rdata",      64'(rsp_rdata), 64'd0);
    chk("lit_to_sel",        64'(last_sel),  64'b1000);
    chk("lit_to_req_cycles", 64'(sv_cnt - base), 64'(TO));
    @(posedge clk); #1;

    // reset mid-REQ, then a normal read
    do_txn(1'b0, 8'h44, 32'd0, TO + 5, 1'b0, 1, 3, 1'b0, 32'd0);
    #1;
    chk("lit_abort_s_valid", 64'(s_valid), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1; in_reset = 1'b0; free_cyc = cyc;
    do_txn(1'b0, 8'h80, 32'd0, 2, 1'b0, 0, -1, 1'b1, 32'h1234_5678);
    @(negedge clk);
    chk("lit_post_abort_rdata", 64'(rsp_rdata), 64'h1234_5678);
    @(posedge clk); #1;

    // back-to-back with cmd_valid held
    do_txn(1'b1, 8'h10, 32'hA5A5_0001, 0, 1'b1, 1, -1, 1'b0, 32'd0);
    do_txn(1'b0, 8'h50, 32'd0,         3, 1'b1, 1, -1, 1'b0, 32'd0);
    do_txn(1'b1, 8'hF0, 32'hA5A5_0003, 1, 1'b0, 1, -1, 1'b0, 32'd0);

    keep_prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!keep_prev) begin
        g = int'($urandom_range(0, 2));
        repeat (g) begin @(posedge clk); #1; end
      end
      d    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO, TO + 3))
                                         : int'($urandom_range(0, 6));
      keep = ($urandom_range(0, 3) == 0);
      do_txn(1'($urandom), 8'($urandom), $urandom, d, keep, 1, -1, 1'b0, 32'd0);
      keep_prev = keep;
    end
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
